pipeline_ctrl: RTL

Central hazard and stall controller for the 5-stage RISC-V pipeline. It drives the write-enable and flush/bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences load-use bubbles, taken-branch flushes, multi-cycle mul/div waits and instruction/data memory wait states. It works alongside `forwarding_unit`, which resolves all other RAW hazards, and keeps a saturating stall-cycle counter.

---
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: register enables, NOP
// insertion for load-use, taken branches, mul/div waits and memory wait states.
module pipeline_ctrl #(
    parameter int unsigned n = 32,
    parameter int unsigned m = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ID_EX_MemRead,
    input  logic [m-1:0] ID_EX_rd,
    input  logic [m-1:0] IF_ID_rs1,
    input  logic [m-1:0] IF_ID_rs2,
    input  logic         IF_ID_use_rs1,
    input  logic         IF_ID_use_rs2,
    input  logic         EX_branch_taken,
    input  logic         EX_muldiv_start,
    input  logic         muldiv_done,
    input  logic         MEM_mem_req,
    input  logic         dmem_ready,
    input  logic         imem_ready,
    output logic         pc_write,
    output logic         IF_ID_write,
    output logic         ID_EX_write,
    output logic         EX_MEM_write,
    output logic         MEM_WB_write,
    output logic         IF_ID_flush,
    output logic         ID_EX_flush,
    output logic         EX_MEM_flush,
    output logic [n-1:0] stall_cycles,
    output logic [1:0]   ctrl_state
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StMdWait = 2'b01,
        StDmWait = 2'b10
    } state_e;

    state_e       state_q, state_d;
    logic         ret_md_q, ret_md_d;
    logic         redirect_pending_q, redirect_pending_d;
    logic [n-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_hit, rs2_hit, load_use, dmem_freeze, muldiv_wait;

    assign rs1_hit     = IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd);
    assign rs2_hit     = IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd);
    assign load_use    = ID_EX_MemRead && (ID_EX_rd != '0) && (rs1_hit || rs2_hit);
    assign dmem_freeze = !dmem_ready && (MEM_mem_req || (state_q == StDmWait));
    assign muldiv_wait = EX_muldiv_start && !muldiv_done;

    always_comb begin
        pc_write           = 1'b1;
        IF_ID_write        = 1'b1;
        ID_EX_write        = 1'b1;
        EX_MEM_write       = 1'b1;
        MEM_WB_write       = 1'b1;
        IF_ID_flush        = 1'b0;
        ID_EX_flush        = 1'b0;
        EX_MEM_flush       = 1'b0;
        state_d            = StRun;
        ret_md_d           = ret_md_q;
        redirect_pending_d = redirect_pending_q;

        if (rst) begin
            pc_write           = 1'b0;
            IF_ID_write        = 1'b0;
            ID_EX_write        = 1'b0;
            EX_MEM_write       = 1'b0;
            MEM_WB_write       = 1'b0;
            IF_ID_flush        = 1'b1;
            ID_EX_flush        = 1'b1;
            EX_MEM_flush       = 1'b1;
            ret_md_d           = 1'b0;
            redirect_pending_d = 1'b0;
        end else if (dmem_freeze) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            state_d      = StDmWait;
            if (state_q != StDmWait) begin
                ret_md_d = (state_q == StMdWait) || muldiv_wait;
            end
        end else if (muldiv_wait) begin
            // Back end drains behind a bubble while the mul/div holds EX.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
            state_d      = StMdWait;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            if (!imem_ready) begin
                redirect_pending_d = 1'b1;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_write    = 1'b0;
            IF_ID_flush = 1'b1;
        end

        // The stale wrong-path fetch is discarded only when IF/ID actually loads.
        if (redirect_pending_q && imem_ready && IF_ID_write) begin
            IF_ID_flush        = 1'b1;
            redirect_pending_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!IF_ID_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + n'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StRun;
            ret_md_q           <= 1'b0;
            redirect_pending_q <= 1'b0;
            stall_cnt_q        <= '0;
        end else begin
            state_q            <= state_d;
            ret_md_q           <= ret_md_d;
            redirect_pending_q <= redirect_pending_d;
            stall_cnt_q        <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign ctrl_state   = state_q;

endmodule
